// File: rtl/bcd_addsub_seq.sv
// Sequential packed-BCD adder/subtractor: one digit per cycle, LSD first, with a
// tens-complement fix-up pass for negative differences. Optional macro: BCD_INPUT_CHECK_EN.
module bcd_addsub_seq #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] x,
    input  logic [4*DIGITS-1:0] y,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                negative,
    output logic                carry
`ifdef BCD_INPUT_CHECK_EN
    ,
    output logic                error
`endif
);

    localparam int W = 4 * DIGITS;
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Nines complement of one BCD digit.
    function automatic logic [3:0] nines(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    // Single decimal digit add with carry; returns {carry_out, digit}.
    function automatic logic [4:0] digit_add(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (sum > 5'd9) begin
            return {1'b1, 4'(sum - 5'd10)};
        end else begin
            return {1'b0, sum[3:0]};
        end
    endfunction

    // Selects digit i from a packed BCD word.
    function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [3:0] i);
        logic [3:0] d;
        d = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (i == 4'(k)) begin
                d = v[4*k +: 4];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

`ifdef BCD_INPUT_CHECK_EN
    // True when any digit of the word is outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            bad = bad | (v[4*k +: 4] > 4'd9);
        end
        return bad;
    endfunction
`endif

    state_t         state_r;
    state_t         next_state_s;
    logic [W-1:0]   x_r;
    logic [W-1:0]   y_r;
    logic [W-1:0]   res_r;
    logic           op_r;
    logic           c_r;
    logic           neg_r;
    logic           carry_fin_r;
    logic [3:0]     idx_r;
    logic [3:0]     op_a_s;
    logic [3:0]     op_b_s;
    logic [4:0]     dsum_s;
    logic           last_s;
    logic           accept_s;
    logic           done_go_s;
`ifdef BCD_INPUT_CHECK_EN
    logic           bad_s;
    logic           err_r;
    logic [3:0]     wait_r;
`endif

    assign last_s   = (idx_r == LAST_IDX);
    assign accept_s = (state_r == IDLE) && start;

`ifdef BCD_INPUT_CHECK_EN
    assign bad_s     = has_bad_digit(x) | has_bad_digit(y);
    // An invalid capture parks in DONE until the normal add latency has elapsed.
    assign done_go_s = (state_r == DONE) && (wait_r == 4'd0);
`else
    assign done_go_s = (state_r == DONE);
`endif

    // Digit datapath operands: CALC adds x and (nines of) y, FIX complements the stored result.
    always_comb begin
        op_a_s = 4'd0;
        op_b_s = 4'd0;
        case (state_r)
            CALC: begin
                op_a_s = digit_at(x_r, idx_r);
                op_b_s = op_r ? nines(digit_at(y_r, idx_r)) : digit_at(y_r, idx_r);
            end
            FIX: begin
                op_a_s = nines(digit_at(res_r, idx_r));
                op_b_s = 4'd0;
            end
            default: begin
                op_a_s = 4'd0;
                op_b_s = 4'd0;
            end
        endcase
        dsum_s = digit_add(op_a_s, op_b_s, c_r);
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef BCD_INPUT_CHECK_EN
                    next_state_s = bad_s ? DONE : CALC;
`else
                    next_state_s = CALC;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    next_state_s = (op_r && !dsum_s[4]) ? FIX : DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FIX;
                end
            end
            DONE: begin
                if (done_go_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, digit index, running carry and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= '0;
            y_r         <= '0;
            res_r       <= '0;
            op_r        <= 1'b0;
            c_r         <= 1'b0;
            neg_r       <= 1'b0;
            carry_fin_r <= 1'b0;
            idx_r       <= 4'd0;
`ifdef BCD_INPUT_CHECK_EN
            err_r       <= 1'b0;
            wait_r      <= 4'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r         <= x;
                        y_r         <= y;
                        op_r        <= op;
                        c_r         <= op;
                        idx_r       <= 4'd0;
                        res_r       <= '0;
                        neg_r       <= 1'b0;
                        carry_fin_r <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
                        err_r       <= bad_s;
                        wait_r      <= bad_s ? 4'(DIGITS) : 4'd0;
`endif
                    end
                end
                CALC, FIX: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (idx_r == 4'(k)) begin
                            res_r[4*k +: 4] <= dsum_s[3:0];
                        end
                    end
                    c_r <= dsum_s[4];
                    if (last_s) begin
                        idx_r <= 4'd0;
                        if (state_r == CALC) begin
                            carry_fin_r <= op_r ? 1'b0 : dsum_s[4];
                            // A borrow out of the top digit means y > x: seed the complement pass.
                            if (op_r && !dsum_s[4]) begin
                                neg_r <= 1'b1;
                                c_r   <= 1'b1;
                            end
                        end
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                DONE: begin
`ifdef BCD_INPUT_CHECK_EN
                    if (wait_r != 4'd0) begin
                        wait_r <= wait_r - 4'd1;
                    end
`endif
                end
                default: begin
                    idx_r <= 4'd0;
                end
            endcase
        end
    end

    // Registered outputs: results load on the done edge and hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
            carry    <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            error    <= 1'b0;
`endif
        end else begin
            busy <= (next_state_s != IDLE);
            done <= done_go_s;
            if (done_go_s) begin
`ifdef BCD_INPUT_CHECK_EN
                if (err_r) begin
                    result   <= '0;
                    negative <= 1'b0;
                    carry    <= 1'b0;
                    error    <= 1'b1;
                end else begin
                    result   <= res_r;
                    negative <= neg_r;
                    carry    <= carry_fin_r;
                    error    <= 1'b0;
                end
`else
                result   <= res_r;
                negative <= neg_r;
                carry    <= carry_fin_r;
`endif
            end
`ifdef BCD_INPUT_CHECK_EN
            else if (accept_s) begin
                error <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/bcd_addsub_seq.md
BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 Parameter: DIGITS, default 3, number of packed BCD digits per operand; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; accepted only in IDLE.
REQ-005 op  input  1  operation select: 0 = add (x+y), 1 = subtract (x-y); sampled with start.
REQ-006 x  input  4*DIGITS  operand x, packed BCD, digit 0 in bits [3:0].
REQ-007 y  input  4*DIGITS  operand y, same packing as x.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  4*DIGITS  packed BCD magnitude of the result.
REQ-011 negative  output  1  subtract only: 1 when y > x.
REQ-012 carry  output  1  add only: 1 when the sum exceeds 10^DIGITS-1; result holds the sum mod 10^DIGITS.
REQ-013 error  output  1  invalid-digit flag; present only under BCD_INPUT_CHECK_EN (REQ-031).

Function
REQ-014 The block SHALL use the FSM states IDLE, CALC, FIX and DONE.
REQ-015 IDLE: start=1 SHALL capture x, y and op into internal registers, clear the digit index and carry-in, and move to CALC.
- Carry-in is cleared for add and set to 1 for subtract.
REQ-016 CALC SHALL process one digit per cycle, least significant digit first.
- Add: digit sum = x_i + y_i + c.
- Subtract: digit sum = x_i + (9 - y_i) + c.
- When the digit sum exceeds 9, subtract 10 and set carry-out to 1.
- Store the result digit and pass carry-out to the next digit.
REQ-017 After digit DIGITS-1 of an add, the FSM SHALL go to DONE, with carry equal to the final carry-out and negative = 0.
REQ-018 After digit DIGITS-1 of a subtract with final carry-out 1, the FSM SHALL go to DONE, with negative = 0 and carry = 0.
REQ-019 After digit DIGITS-1 of a subtract with final carry-out 0, the FSM SHALL go to FIX with negative = 1.
REQ-020 FIX SHALL replace the stored result with its tens complement, one digit per cycle, LSD first.
- Each digit becomes 9 - r_i + c, with initial c = 1 and decimal carry as in REQ-016.
- After the last digit the FSM goes to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 Latency from the edge that accepts start to the done cycle SHALL be:
- DIGITS+1 cycles for an add, or for a subtract with y <= x;
- 2*DIGITS+1 cycles for a subtract with y > x.
REQ-023 result, negative and carry SHALL hold their values from the done cycle until the next start is accepted.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-025 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE.
REQ-026 x == y in subtract SHALL give result all zeros and negative = 0; a negative zero is never produced.
REQ-027 Changes on x, y and op after capture SHALL NOT affect the operation in flight.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge and clear busy, done, result, negative, carry, error and all internal registers to 0.
REQ-029 rst asserted mid-operation SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-030 When rst and start are both high, rst SHALL win.

Configuration
REQ-031 With the macro BCD_INPUT_CHECK_EN defined:
- Any captured digit of x or y greater than 9 SHALL send the FSM from IDLE straight to DONE.
- done pulses DIGITS+1 cycles after the accepting edge.
- error = 1, and result, negative and carry = 0.
- error holds until the next start is accepted or reset.
REQ-032 Without BCD_INPUT_CHECK_EN:
- The error port and checking logic SHALL be absent.
- Invalid digits produce unspecified but deterministic result values.
- Timing is per REQ-022.

Verification (DIGITS=3)
REQ-033 Add 0x456 + 0x789 -> result 0x245, carry 1, negative 0, done 4 cycles after the start edge.
REQ-034 Subtract 0x500 - 0x123 -> result 0x377, negative 0, done at 4 cycles; then 0x123 - 0x500 -> result 0x377, negative 1, done at 7 cycles.
REQ-035 Subtract 0x250 - 0x250 -> result 0x000, negative 0; add 0x999 + 0x001 -> result 0x000, carry 1.
REQ-036 Start a subtract, pulse start again with new operands during CALC -> first result is unaffected and only one done pulse occurs; pulse rst during FIX -> IDLE, outputs 0, no done.
REQ-037 With BCD_INPUT_CHECK_EN: x = 0x1A3, y = 0x001 -> error 1, result 0x000, done at 4 cycles; the next valid start clears error.
